// File: rtl/instr_cycle_ctrl.sv
// Instruction-cycle sequencer for the two-address machine: walks phases 1..7,0 per instruction,
// owns PC / memory address / opcode and handshakes memory and ALU requests with a reply timeout.
module instr_cycle_ctrl #(
  parameter logic [11:0] START_ADDR  = 12'o0001,
  parameter logic [5:0]  HALT_OP     = 6'o77,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  input  logic [30:0] c_in,
  input  logic        mem_reply,
  input  logic        operate_reply,
  output logic [2:0]  pulse,
  output logic [11:0] reg_start,
  output logic [11:0] reg_select,
  output logic [5:0]  operator,
  output logic        mem_read_pulse,
  output logic        mem_write_pulse,
  output logic        operate_pulse,
  output logic        c_load,
  output logic        a_load,
  output logic        b_load,
  output logic        busy,
  output logic        timeout_err
);

  // state    | meaning
  // S_IDLE   | no instruction in progress, waiting for run/step
  // S_FETCH  | phase 1: instruction read at reg_start
  // S_DECODE | phase 2: latch opcode and operand addresses
  // S_RD1    | phase 3: operand-1 read
  // S_LD_A   | phase 4: datapath copies reg_c into reg_a
  // S_RD2    | phase 5: operand-2 read
  // S_LD_B   | phase 6: datapath copies reg_c into reg_b
  // S_OPER   | phase 7: ALU operate
  // S_WRITE  | phase 0: write-back to operand-2 address
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_RD1    = 4'd3,
    S_LD_A   = 4'd4,
    S_RD2    = 4'd5,
    S_LD_B   = 4'd6,
    S_OPER   = 4'd7,
    S_WRITE  = 4'd8
  } state_t;

  localparam logic [15:0] WAIT_LOAD = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [11:0] addr2;
  logic [15:0] wait_cnt;
  logic        armed;
  logic        req_any;
  logic        reply_seen;
  logic        wait_tc;
  logic        unused_c_in_msb;

  assign unused_c_in_msb = c_in[30];

  // A reply only counts from the second cycle of a request phase onward.
  assign req_any    = mem_read_pulse | mem_write_pulse | operate_pulse;
  assign reply_seen = armed & (((mem_read_pulse | mem_write_pulse) & mem_reply) |
                               (operate_pulse & operate_reply));
  assign wait_tc    = (wait_cnt == 16'd0);

  assign c_load = mem_read_pulse & mem_reply & armed;
  assign a_load = busy & (pulse == 3'd4);
  assign b_load = busy & (pulse == 3'd6);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      pulse           <= 3'd0;
      reg_start       <= START_ADDR;
      reg_select      <= 12'd0;
      operator        <= 6'o77;
      addr2           <= 12'd0;
      mem_read_pulse  <= 1'b0;
      mem_write_pulse <= 1'b0;
      operate_pulse   <= 1'b0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
      wait_cnt        <= 16'd0;
      armed           <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (req_any && !reply_seen && wait_tc) begin
        mem_read_pulse  <= 1'b0;
        mem_write_pulse <= 1'b0;
        operate_pulse   <= 1'b0;
        timeout_err     <= 1'b1;
        busy            <= 1'b0;
        pulse           <= 3'd0;
        state           <= S_IDLE;
      end else begin
        if (req_any && !reply_seen) begin
          wait_cnt <= wait_cnt - 16'd1;
        end
        case (state)
          S_IDLE: begin
            if ((run || step) && !timeout_err) begin
              state          <= S_FETCH;
              busy           <= 1'b1;
              pulse          <= 3'd1;
              reg_select     <= reg_start;
              mem_read_pulse <= 1'b1;
              armed          <= 1'b0;
              wait_cnt       <= WAIT_LOAD;
            end
          end
          S_FETCH: begin
            if (reply_seen) begin
              mem_read_pulse <= 1'b0;
              pulse          <= 3'd2;
              state          <= S_DECODE;
            end
          end
          S_DECODE: begin
            operator       <= c_in[29:24];
            reg_select     <= c_in[23:12];
            addr2          <= c_in[11:0];
            reg_start      <= reg_start + 12'd1;
            mem_read_pulse <= 1'b1;
            pulse          <= 3'd3;
            state          <= S_RD1;
            armed          <= 1'b0;
            wait_cnt       <= WAIT_LOAD;
          end
          S_RD1: begin
            if (reply_seen) begin
              mem_read_pulse <= 1'b0;
              pulse          <= 3'd4;
              state          <= S_LD_A;
            end
          end
          S_LD_A: begin
            reg_select     <= addr2;
            mem_read_pulse <= 1'b1;
            pulse          <= 3'd5;
            state          <= S_RD2;
            armed          <= 1'b0;
            wait_cnt       <= WAIT_LOAD;
          end
          S_RD2: begin
            if (reply_seen) begin
              mem_read_pulse <= 1'b0;
              pulse          <= 3'd6;
              state          <= S_LD_B;
            end
          end
          S_LD_B: begin
            operate_pulse <= 1'b1;
            pulse         <= 3'd7;
            state         <= S_OPER;
            armed         <= 1'b0;
            wait_cnt      <= WAIT_LOAD;
          end
          S_OPER: begin
            if (reply_seen) begin
              operate_pulse   <= 1'b0;
              mem_write_pulse <= 1'b1;
              pulse           <= 3'd0;
              state           <= S_WRITE;
              armed           <= 1'b0;
              wait_cnt        <= WAIT_LOAD;
            end
          end
          S_WRITE: begin
            if (reply_seen) begin
              mem_write_pulse <= 1'b0;
              // Halt or a dropped run ends the sequence after the write-back.
              if ((operator == HALT_OP) || !run) begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                pulse          <= 3'd1;
                reg_select     <= reg_start;
                mem_read_pulse <= 1'b1;
                state          <= S_FETCH;
                armed          <= 1'b0;
                wait_cnt       <= WAIT_LOAD;
              end
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Self-checking bench for instr_cycle_ctrl: random-latency memory/ALU responder plus a
// transaction-level model of the expected request stream, pulse trace and PC progression.
module tb_instr_cycle_ctrl;

  localparam logic [11:0] START = 12'o7777;
  localparam logic [5:0]  HALT  = 6'o77;
  localparam int          TMO   = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [30:0] c_in = '0;
  logic        mem_reply = 1'b0;
  logic        operate_reply = 1'b0;
  logic [2:0]  pulse;
  logic [11:0] reg_start;
  logic [11:0] reg_select;
  logic [5:0]  operator;
  logic        mem_read_pulse;
  logic        mem_write_pulse;
  logic        operate_pulse;
  logic        c_load;
  logic        a_load;
  logic        b_load;
  logic        busy;
  logic        timeout_err;

  instr_cycle_ctrl #(.START_ADDR(START), .HALT_OP(HALT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .c_in(c_in),
    .mem_reply(mem_reply), .operate_reply(operate_reply), .pulse(pulse),
    .reg_start(reg_start), .reg_select(reg_select), .operator(operator),
    .mem_read_pulse(mem_read_pulse), .mem_write_pulse(mem_write_pulse),
    .operate_pulse(operate_pulse), .c_load(c_load), .a_load(a_load), .b_load(b_load),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [30:0] mem [4096];
  logic [13:0] obs_txn[$], exp_txn[$];
  logic [2:0]  obs_pulse[$], exp_pulse[$];
  logic [11:0] obs_pc[$], exp_pc[$];
  int a_cnt = 0;
  int b_cnt = 0;
  int stall_high = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] rand_word(input bit halt);
    logic [30:0] w;
    w = 31'($urandom);
    w[29:24] = halt ? HALT : 6'($urandom_range(0, 62));
    return w;
  endfunction

  // Expected activity of n consecutive instructions starting at pc0.
  task automatic build_expect(input logic [11:0] pc0, input int n);
    logic [11:0] pc;
    logic [30:0] w;
    pc = pc0;
    for (int i = 0; i < n; i++) begin
      w = mem[pc];
      exp_txn.push_back({2'd1, pc});
      exp_txn.push_back({2'd1, w[23:12]});
      exp_txn.push_back({2'd1, w[11:0]});
      exp_txn.push_back({2'd3, 12'd0});
      exp_txn.push_back({2'd2, w[11:0]});
      pc = pc + 12'd1;
      exp_pc.push_back(pc);
      for (int p = 1; p <= 8; p++) exp_pulse.push_back(3'(p % 8));
    end
  endtask

  function automatic int instrs_to_halt(input logic [11:0] pc0);
    logic [11:0] pc;
    pc = pc0;
    for (int i = 1; i <= 64; i++) begin
      if (mem[pc][29:24] == HALT) return i;
      pc = pc + 12'd1;
    end
    return 64;
  endfunction

  task automatic clear_q();
    obs_txn.delete(); exp_txn.delete();
    obs_pulse.delete(); exp_pulse.delete();
    obs_pc.delete(); exp_pc.delete();
    a_cnt = 0; b_cnt = 0;
  endtask

  task automatic compare_run(input string tag, input int n);
    int m;
    chk({tag, "_txn_count"}, obs_txn.size(), exp_txn.size());
    m = (obs_txn.size() < exp_txn.size()) ? obs_txn.size() : exp_txn.size();
    for (int i = 0; i < m; i++) chk({tag, "_txn"}, obs_txn[i], exp_txn[i]);
    chk({tag, "_pulse_count"}, obs_pulse.size(), exp_pulse.size());
    m = (obs_pulse.size() < exp_pulse.size()) ? obs_pulse.size() : exp_pulse.size();
    for (int i = 0; i < m; i++) chk({tag, "_pulse"}, obs_pulse[i], exp_pulse[i]);
    chk({tag, "_pc_count"}, obs_pc.size(), exp_pc.size());
    m = (obs_pc.size() < exp_pc.size()) ? obs_pc.size() : exp_pc.size();
    for (int i = 0; i < m; i++) chk({tag, "_pc_at_p3"}, obs_pc[i], exp_pc[i]);
    chk({tag, "_a_load_cycles"}, a_cnt, n);
    chk({tag, "_b_load_cycles"}, b_cnt, n);
    clear_q();
  endtask

  // Responder: answers each request after a random latency of 1..4 cycles (1 = reply in the
  // unarmed first cycle), drives noise on reply lines that have nothing pending.
  task automatic service(input int max_cyc, input int stall_req, input int drop_after,
                         input bit step_busy, input bit stop_p5);
    logic [2:0]  vec, prev_vec, last_pulse;
    logic [30:0] next_c;
    logic        give;
    int age, lat, req_idx, n_txn, cyc;
    bit seen_busy, early, done, upd_c;
    prev_vec = 3'b000; last_pulse = 3'd0; next_c = '0;
    age = 0; lat = 1; req_idx = -1; n_txn = 0; cyc = 0;
    seen_busy = 0; early = 0; done = 0; upd_c = 0;
    while (!done && cyc < max_cyc) begin
      vec = {mem_read_pulse, mem_write_pulse, operate_pulse};
      if (early) begin
        chk("first_cycle_reply_not_counted", vec, prev_vec);
        early = 0;
      end
      if (vec != 3'b000) begin
        if (vec == prev_vec) age++;
        else begin
          age = 1; req_idx++; lat = $urandom_range(1, 4);
        end
      end else age = 0;
      prev_vec = vec;
      if (busy) begin
        seen_busy = 1;
        if (pulse != last_pulse) begin
          obs_pulse.push_back(pulse);
          if (pulse == 3'd3) obs_pc.push_back(reg_start);
          last_pulse = pulse;
        end
      end
      a_cnt += int'(a_load);
      b_cnt += int'(b_load);
      step = step_busy && busy && (pulse == 3'd4);
      mem_reply = 1'($urandom_range(0, 1));
      operate_reply = 1'($urandom_range(0, 1));
      if (vec != 3'b000) begin
        give = (req_idx != stall_req) && (age >= lat);
        if (req_idx == stall_req) stall_high++;
        if (vec[0]) operate_reply = give;
        else mem_reply = give;
        if (give && age == 1) early = 1;
        if (give && age >= 2) begin
          if (vec[2]) begin
            obs_txn.push_back({2'd1, reg_select});
            next_c = mem[reg_select];
            upd_c = 1;
          end else if (vec[1]) obs_txn.push_back({2'd2, reg_select});
          else obs_txn.push_back({2'd3, 12'd0});
          n_txn++;
          if (n_txn == drop_after) run = 1'b0;
        end
      end
      #1;
      chk("c_load", c_load, vec[2] && mem_reply && (age >= 2));
      @(posedge clk);
      #1;
      if (upd_c) begin
        c_in = next_c;
        upd_c = 0;
      end
      cyc++;
      if (timeout_err || (seen_busy && !busy) || (stop_p5 && pulse == 3'd5)) done = 1;
    end
    chk("service_finished_within_budget", done, 1'b1);
    step = 1'b0; mem_reply = 1'b0; operate_reply = 1'b0;
  endtask

  task automatic idle_quiet(input string tag, input int cycles);
    int active;
    active = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (busy || mem_read_pulse || mem_write_pulse || operate_pulse) active++;
    end
    chk(tag, active, 0);
  endtask

  initial begin
    logic [11:0] pc_model;
    int n, k;
    for (int i = 0; i < 4096; i++) mem[i] = rand_word($urandom_range(0, 7) == 0);

    // Reset state
    #12;
    chk("rst_pulse", pulse, 3'd0);
    chk("rst_reg_start", reg_start, START);
    chk("rst_reg_select", reg_select, 12'd0);
    chk("rst_operator", operator, 6'o77);
    chk("rst_requests", {mem_read_pulse, mem_write_pulse, operate_pulse}, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: PC wrap 7777->0000, then a halt instruction at 0000
    mem[12'o7777] = {1'b0, 6'o00, 12'o1111, 12'o2222};
    mem[12'o0000] = {1'b0, 6'o77, 12'o0005, 12'o0006};
    build_expect(START, 2);
    run = 1'b1;
    service(400, -1, -1, 1'b0, 1'b0);
    run = 1'b0;
    compare_run("directed", 2);
    chk("directed_reg_start", reg_start, 12'o0001);
    chk("directed_operator", operator, 6'o77);
    chk("directed_reg_select", reg_select, 12'o0006);
    chk("directed_busy", busy, 1'b0);
    chk("directed_pulse", pulse, 3'd0);
    idle_quiet("directed_idle_quiet", 10);
    pc_model = 12'o0001;

    // Single step with run=0, plus a step pulse while busy that must be ignored
    mem[pc_model] = rand_word(1'b0);
    build_expect(pc_model, 1);
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
    service(400, -1, -1, 1'b1, 1'b0);
    compare_run("step", 1);
    chk("step_reg_start", reg_start, pc_model + 12'd1);
    idle_quiet("step_idle_quiet", 20);
    pc_model = pc_model + 12'd1;

    // Random programs run to a halt
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n - 1; i++) mem[pc_model + 12'(i)] = rand_word(1'b0);
      mem[pc_model + 12'(n - 1)] = rand_word(1'b1);
      n = instrs_to_halt(pc_model);
      build_expect(pc_model, n);
      run = 1'b1;
      service(600, -1, -1, 1'b0, 1'b0);
      run = 1'b0;
      compare_run("random_run", n);
      pc_model = pc_model + 12'(n);
      chk("random_run_reg_start", reg_start, pc_model);
    end

    // run dropped mid-stream: the instruction in progress finishes, then idle
    for (int r = 0; r < 2; r++) begin
      k = (r == 0) ? 5 : $urandom_range(6, 10);
      n = (k + 4) / 5;
      for (int i = 0; i < 4; i++) mem[pc_model + 12'(i)] = rand_word(1'b0);
      build_expect(pc_model, n);
      run = 1'b1;
      service(600, -1, k, 1'b0, 1'b0);
      run = 1'b0;
      compare_run("run_drop", n);
      idle_quiet("run_drop_idle_quiet", 10);
      pc_model = pc_model + 12'(n);
    end

    // Asynchronous reset in the middle of phase 5
    mem[pc_model] = rand_word(1'b0);
    run = 1'b1;
    service(400, -1, -1, 1'b0, 1'b1);
    chk("midp5_reached", pulse, 3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    run = 1'b0;
    chk("midp5_rst_pulse", pulse, 3'd0);
    chk("midp5_rst_reg_start", reg_start, START);
    chk("midp5_rst_reg_select", reg_select, 12'd0);
    chk("midp5_rst_operator", operator, 6'o77);
    chk("midp5_rst_requests", {mem_read_pulse, mem_write_pulse, operate_pulse}, 3'b000);
    chk("midp5_rst_busy", busy, 1'b0);
    clear_q();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reply withheld in phase 3 -> timeout, then run ignored until reset
    mem[START] = rand_word(1'b0);
    stall_high = 0;
    run = 1'b1;
    service(400, 1, -1, 1'b0, 1'b0);
    chk("timeout_request_cycles", stall_high, TMO);
    chk("timeout_err_set", timeout_err, 1'b1);
    chk("timeout_requests", {mem_read_pulse, mem_write_pulse, operate_pulse}, 3'b000);
    chk("timeout_busy", busy, 1'b0);
    chk("timeout_pulse", pulse, 3'd0);
    clear_q();
    step = 1'b1;
    idle_quiet("timeout_run_ignored", 30);
    step = 1'b0;
    chk("timeout_err_sticky", timeout_err, 1'b1);
    run = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("timeout_err_cleared", timeout_err, 1'b0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Recovery after reset: one stepped instruction
    build_expect(START, 1);
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
    service(400, -1, -1, 1'b0, 1'b0);
    compare_run("recovery", 1);
    chk("recovery_reg_start", reg_start, 12'o0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
